// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port registered-read DMEM.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int n       = 8,
  parameter int address = 11
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req0_i,
  input  logic               req1_i,
  input  logic               we0_i,
  input  logic               we1_i,
  input  logic [address-1:0] addr0_i,
  input  logic [address-1:0] addr1_i,
  input  logic [n-1:0]       wdata0_i,
  input  logic [n-1:0]       wdata1_i,
  output logic               gnt0_o,
  output logic               gnt1_o,
  output logic               rvalid0_o,
  output logic               rvalid1_o,
  output logic [n-1:0]       rdata0_o,
  output logic [n-1:0]       rdata1_o,
  output logic [address-1:0] mem_addr_o,
  output logic [n-1:0]       mem_st_data_o,
  output logic               mem_st_en_o,
  input  logic [n-1:0]       mem_ld_data_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q;
  logic   win_q;
  logic   we_q;
  logic   any_req;
  logic   prefer1;
  logic   pick;

`ifdef DMEM_ARB_RR_EN
  assign prefer1 = ~last_q;
`else
  // Fixed priority never consults last_q; it is still tracked so both builds share state.
  assign prefer1 = 1'b0 & last_q;
`endif

  // pick = 1 selects port 1
  assign any_req = req0_i | req1_i;
  assign pick    = req1_i & (~req0_i | prefer1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      win_q         <= 1'b0;
      we_q          <= 1'b0;
      mem_addr_o    <= '0;
      mem_st_data_o <= '0;
      rdata0_o      <= '0;
      rdata1_o      <= '0;
      rvalid0_o     <= 1'b0;
      rvalid1_o     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rvalid0_o <= 1'b0;
      rvalid1_o <= 1'b0;
      if (state_q == IDLE && any_req) begin
        win_q         <= pick;
        last_q        <= pick;
        we_q          <= pick ? we1_i    : we0_i;
        mem_addr_o    <= pick ? addr1_i  : addr0_i;
        mem_st_data_o <= pick ? wdata1_i : wdata0_i;
      end
      if (state_q == RESP) begin
        if (win_q) begin
          rdata1_o  <= mem_ld_data_i;
          rvalid1_o <= 1'b1;
        end else begin
          rdata0_o  <= mem_ld_data_i;
          rvalid0_o <= 1'b1;
        end
      end
    end
  end

  assign gnt0_o      = (state_q == ACCESS) & ~win_q;
  assign gnt1_o      = (state_q == ACCESS) &  win_q;
  assign mem_st_en_o = (state_q == ACCESS) &  we_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer sitting in front of the single-port 8-bit data memory (DMEM) in the MCU. It shares DMEM between requester 0 (the core load/store unit) and requester 1 (debug/DMA port). For each granted access it drives the DMEM address, store data and store enable, and returns load data to the winning requester with a valid pulse.

## Interface
- `n`, default 8: data width; matches DMEM word width.
- `address`, default 11: address width; matches DMEM address width.

- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_ni` input 1: asynchronous active-low reset.
- `req0_i`, `req1_i` input 1 each: access request; held high with stable we/addr/wdata until the matching gnt.
- `we0_i`, `we1_i` input 1 each: 1 = store, 0 = load.
- `addr0_i`, `addr1_i` input `address` each: word address.
- `wdata0_i`, `wdata1_i` input `n` each: store data.
- `gnt0_o`, `gnt1_o` output 1 each: one-cycle pulse; the request is accepted and its memory cycle is occurring.
- `rvalid0_o`, `rvalid1_o` output 1 each: one-cycle pulse; the corresponding `rdata` carries the load result.
- `rdata0_o`, `rdata1_o` output `n` each: registered load data; holds its value between loads.
- `mem_addr_o` output `address`: DMEM address.
- `mem_st_data_o` output `n`: DMEM store data.
- `mem_st_en_o` output 1: DMEM store enable.
- `mem_ld_data_i` input `n`: DMEM load data; valid the cycle after `mem_addr_o` is presented (registered read).
- `busy_o` output 1: high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: samples requests.
    - No request: stays in IDLE.
    - Any request: registers the winner's we/addr/wdata into the mem_* outputs and goes to ACCESS.
  - ACCESS, 1 cycle: `gnt<k>_o`=1 and `busy_o`=1; `mem_st_en_o` equals the winner's we.
    - Store: goes to IDLE.
    - Load: goes to RESP.
  - RESP, 1 cycle: `mem_ld_data_i` is valid and is captured into `rdata<k>_o` at the end of the cycle.
    - `rvalid<k>_o` is registered high for the following cycle, which is an IDLE cycle.
    - Goes to IDLE.
- `mem_st_en_o` is high only in ACCESS of a store; it is 0 in every other state.
- `mem_addr_o` and `mem_st_data_o` hold their last value outside ACCESS/RESP.
- Winner selection when both ports request in IDLE: see Configuration. A lone request always wins.
- A port tracker `last` records the most recently granted port; it updates on entry to ACCESS.
- Requests are not sampled in ACCESS or RESP.
- A requester may drop or change its request from the cycle after its gnt.
- Data is passed unmodified, with no width conversion. Address wrap-around is DMEM's concern; the arbiter passes the full `address` bits.
- Reset values:
  - State IDLE; `last`=1, so port 0 wins the first conflict.
  - All gnt/rvalid 0, `mem_st_en_o`=0, `busy_o`=0.
  - `mem_addr_o`=0, `mem_st_data_o`=0, both rdata=0.
- Reset mid-operation (ACCESS or RESP) aborts the access immediately and asynchronously.
  - `mem_st_en_o` drops with reset.
  - No gnt or rvalid is issued after reset release.
  - The aborted request must be re-presented.

## Timing
- Request seen high in IDLE in cycle 0:
  - gnt in cycle 1.
  - Store: `mem_st_en_o` high in cycle 1 only; the next request is sampled in cycle 2.
  - Load: RESP in cycle 2; `rvalid` and `rdata` in cycle 3. The next request is sampled in cycle 3, in parallel with `rvalid`.
- Throughput: one store per 2 cycles; one load per 3 cycles.
- gnt0/gnt1 and rvalid0/rvalid1 are never high simultaneously.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. On a conflict, the port not equal to `last` wins, so continuous dual requests alternate 0,1,0,1…
- `DMEM_ARB_RR_EN` undefined: fixed priority. Port 0 always wins a conflict; port 1 can starve. `last` is still maintained but unused.

## Test plan
- Reset: assert `rst_ni`=0 with random inputs -> every output is 0 and `busy_o`=0. Release -> outputs stay 0 until a request arrives.
- Port 0 store then load: store addr 0x005, data 0xA5 -> `gnt0_o` and `mem_st_en_o` high in cycle 1 with `mem_addr_o`=0x005. Load 0x005 -> `rvalid0_o`=1 with `rdata0_o`=0xA5 exactly 3 cycles after the request is first seen.
- Conflict with `DMEM_ARB_RR_EN`: both ports hold load requests (addr0=0x010 with data 0x11, addr1=0x020 with data 0x22) -> grant order is port 0 then port 1; `rdata0_o`=0x11 and `rdata1_o`=0x22; rvalids are on distinct cycles.
- Without the macro: both ports request stores continuously for 10 cycles -> only `gnt0_o` pulses (cycles 1,3,5,7,9); `gnt1_o` stays 0.
- Reset during RESP of a port 1 load -> `rvalid1_o` never pulses, `rdata1_o`=0, state IDLE, and a fresh request is granted normally afterward.
- Back-to-back port 1 stores to 0x7FF with data 0xFF, then 0x000 with data 0x01 -> `gnt1_o` pulses two cycles apart. Reading back both addresses returns 0xFF and 0x01.
